sal_cmd_sched: RTL
==================

SAL_CMD_SCHED -- requirements
Module: SAL_CMD_SCHED

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of bank-controller requesters (2..8).
REQ-002 SHALL have parameter TW, default 4, meaning width of timing config fields and internal timers.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester command request.
REQ-006 SHALL have port req_cmd  input  NUM_REQ x 3  per-requester command code (cmd_t: NOP, ACT, RD, WR, PRE).
REQ-007 SHALL have port req_grant  output  NUM_REQ  one-hot combinational grant; accepted when req_valid & req_grant.
REQ-008 SHALL have port ref_req  input  1  refresh request, level, held until ref_ack.
REQ-009 SHALL have port ref_ack  output  1  one-cycle combinational refresh grant.
REQ-010 SHALL have ports cfg_trrd, cfg_tccd, cfg_twtr, cfg_trtw  input  TW each  ACT-ACT, CAS-CAS, WR-RD, RD-WR gaps in cycles; static while requests are active.
REQ-011 SHALL have port cmd_valid  output  1  registered issued-command strobe to the DFI command driver.
REQ-012 SHALL have port cmd_code  output  3  registered cmd_t of the issued command (REF uses dedicated code).
REQ-013 SHALL have port cmd_src  output  $clog2(NUM_REQ)  registered index of the issuing requester (0 for REF).

Function
REQ-014 SHALL grant at most one of {ref_ack, req_grant bits} per cycle.
REQ-015 SHALL consider a requester eligible: ACT if act_tmr==0; RD if cas_tmr==0 and wtr_tmr==0; WR if cas_tmr==0 and rtw_tmr==0; PRE always; NOP never.
REQ-016 SHALL pick among eligible requesters round-robin starting at rr_ptr; after a grant rr_ptr = winner+1 mod NUM_REQ; no grant leaves rr_ptr unchanged.
REQ-017 SHALL, while ref_req=1, grant no requester; assert ref_ack when all four timers are 0.
REQ-018 SHALL load timers on issue: ACT -> act_tmr=max(cfg_trrd,1)-1; RD/WR -> cas_tmr=max(cfg_tccd,1)-1; WR -> wtr_tmr=max(cfg_twtr,1)-1; RD -> rtw_tmr=max(cfg_trtw,1)-1.
REQ-019 SHALL decrement each nonzero timer by 1 per cycle, saturating at 0; load overrides decrement in the same cycle.
REQ-020 SHALL drive cmd_valid/cmd_code/cmd_src exactly one cycle after the accepting grant (latency 1); cmd_valid=0 otherwise.
REQ-021 SHALL treat requester dropping req_valid while granted as no-accept: no command issued, rr_ptr unchanged, timers unchanged.
REQ-022 SHALL, with cfg value 0 or 1, allow the same command class back-to-back on consecutive cycles.

Reset
REQ-023 SHALL, on rst_n=0, immediately clear cmd_valid, cmd_code (NOP), cmd_src, rr_ptr and all timers to 0, independent of clk.
REQ-024 SHALL, during reset, hold req_grant=0 and ref_ack=0; an in-flight command is dropped, not replayed.

Structure
REQ-025 SHALL take cmd_t encoding (NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5) from shared package SAL_SCHED_PKG, also used by bank controllers and DFI driver.
REQ-026 SHALL implement the round-robin picker as sub-module SAL_RR_ARB (NUM_REQ-wide request, pointer in, one-hot grant out).

Verification
REQ-027 Req0..3 all RD continuously, cfg_tccd=2 -> cmd_src 0,1,2,3,0 on every second cycle, cmd_valid alternating 1/0.
REQ-028 Req1 WR then req2 RD, cfg_twtr=4, cfg_tccd=1 -> RD issued exactly 4 cycles after WR on cmd bus.
REQ-029 Req0 ACT and req1 ACT same cycle, cfg_trrd=3 -> req0 first (rr_ptr=0), req1 ACT 3 cycles later; req2 PRE granted in gap cycles.
REQ-030 ref_req raised while cas_tmr=3 -> no requester grants, ref_ack after timers drain, cmd_code=REF next cycle, then round-robin resumes.
REQ-031 rst_n low mid-stream with timers nonzero -> all outputs 0 asynchronously; after release first request granted in the first cycle with no stale timer gap.

Source files
------------

// File: rtl/sal_sched_pkg.sv
// Shared command encoding for bank controllers,
// the command scheduler and the DFI driver.
package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

endpackage

// File: rtl/sal_rr_arb.sv
// Round-robin picker: first set request at or
// after ptr, wrapping, as a one-hot grant.
module sal_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int PW = $clog2(N);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_cmd_sched.sv
// DRAM command scheduler: round-robin among bank
// controllers under tRRD/tCCD/tWTR/tRTW, refresh first.
module sal_cmd_sched
  import sal_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TW      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0][2:0]    req_cmd,
  output logic [NUM_REQ-1:0]         req_grant,
  input  logic                       ref_req,
  output logic                       ref_ack,
  input  logic [TW-1:0]              cfg_trrd,
  input  logic [TW-1:0]              cfg_tccd,
  input  logic [TW-1:0]              cfg_twtr,
  input  logic [TW-1:0]              cfg_trtw,
  output logic                       cmd_valid,
  output logic [2:0]                 cmd_code,
  output logic [$clog2(NUM_REQ)-1:0] cmd_src
);

  localparam int SW = $clog2(NUM_REQ);

  logic [TW-1:0] act_q, act_d;
  logic [TW-1:0] cas_q, cas_d;
  logic [TW-1:0] wtr_q, wtr_d;
  logic [TW-1:0] rtw_q, rtw_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [2:0]    cmd_code_q, cmd_code_d;
  logic [SW-1:0] cmd_src_q, cmd_src_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] accept;
  logic               win;
  logic [SW-1:0]      win_idx;
  cmd_t               win_cmd;
  logic               tmr_idle;

  // A gap of 0 or 1 cycles both allow back-to-back issue.
  function automatic logic [TW-1:0] ld(
    input logic [TW-1:0] c
  );
    return (c == '0) ? '0 : c - TW'(1);
  endfunction

  assign tmr_idle = (act_q == '0) && (cas_q == '0)
                 && (wtr_q == '0) && (rtw_q == '0);

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      case (cmd_t'(req_cmd[i]))
        CMD_ACT: elig[i] = (act_q == '0);
        CMD_RD:  elig[i] = (cas_q == '0) && (wtr_q == '0);
        CMD_WR:  elig[i] = (cas_q == '0) && (rtw_q == '0);
        CMD_PRE: elig[i] = 1'b1;
        default: elig[i] = 1'b0;
      endcase
    end
  end

  assign arb_req = (ref_req || !rst_n) ? '0
                 : (elig & req_valid);

  sal_rr_arb #(
    .N (NUM_REQ)
  ) u_arb (
    .req (arb_req),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign req_grant = gnt;
  assign ref_ack   = rst_n && ref_req && tmr_idle;
  assign accept    = req_valid & gnt;
  assign win       = |accept;

  always_comb begin
    win_idx = '0;
    win_cmd = CMD_NOP;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        win_idx = SW'(i);
        win_cmd = cmd_t'(req_cmd[i]);
      end
    end
  end

  always_comb begin
    act_d = (act_q != '0) ? act_q - TW'(1) : act_q;
    cas_d = (cas_q != '0) ? cas_q - TW'(1) : cas_q;
    wtr_d = (wtr_q != '0) ? wtr_q - TW'(1) : wtr_q;
    rtw_d = (rtw_q != '0) ? rtw_q - TW'(1) : rtw_q;
    rr_ptr_d    = rr_ptr_q;
    cmd_valid_d = win || ref_ack;
    cmd_code_d  = CMD_NOP;
    cmd_src_d   = '0;
    if (ref_ack) begin
      cmd_code_d = CMD_REF;
    end else if (win) begin
      cmd_code_d = win_cmd;
      cmd_src_d  = win_idx;
      rr_ptr_d   = (win_idx == SW'(NUM_REQ - 1))
                 ? '0 : win_idx + SW'(1);
      case (win_cmd)
        CMD_ACT: act_d = ld(cfg_trrd);
        CMD_RD: begin
          cas_d = ld(cfg_tccd);
          rtw_d = ld(cfg_trtw);
        end
        CMD_WR: begin
          cas_d = ld(cfg_tccd);
          wtr_d = ld(cfg_twtr);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q       <= '0;
      cas_q       <= '0;
      wtr_q       <= '0;
      rtw_q       <= '0;
      rr_ptr_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_NOP;
      cmd_src_q   <= '0;
    end else begin
      act_q       <= act_d;
      cas_q       <= cas_d;
      wtr_q       <= wtr_d;
      rtw_q       <= rtw_d;
      rr_ptr_q    <= rr_ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_src_q   <= cmd_src_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_src   = cmd_src_q;

endmodule
